// File: rtl/echo_pkg.sv
// Shared types and arithmetic helpers for the multichannel echo block.
package echo_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_FEEDBACK = 2'd1,
    MODE_FEEDFWD  = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam int unsigned ACC_W     = 64;
  localparam int unsigned SUM_SHIFT = 0;

  // Round-half-up by 'shift' bits, then saturate to a signed 'width'-bit range.
  function automatic logic signed [ACC_W-1:0] round_and_clip(
    input  logic signed [ACC_W-1:0] v,
    input  int unsigned             shift,
    input  int unsigned             width,
    output logic                    clip
  );
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    r = v;
    if (shift != 0) begin
      r = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi   = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (width - 1));
    clip = 1'b0;
    if (r > hi) begin
      r    = hi;
      clip = 1'b1;
    end else if (r < lo) begin
      r    = lo;
      clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_mc_if.sv
// AXI-stream style sample channel used on both sides of echo_mc.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay-line memory: one write port, one synchronous read port.
module echo_delay_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8192
) (
  input  logic                     pi_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read samples the array before this edge's write lands (read-before-write).
  always_ff @(posedge pi_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/echo_mc.sv
// Multichannel echo: per-sample feedback / feed-forward echo with dry and echo gains.
module echo_mc
  import echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MAX_DELAY  = 4096
) (
  input  logic                         pi_clk,
  input  logic                         pi_areset_n,
  axis_if.slave                        pi_data,
  axis_if.master                       po_data,
  input  logic [1:0]                   pi_mode,
  input  logic [$clog2(MAX_DELAY):0]   pi_delay,
  input  logic [DATA_WIDTH-1:0]        pi_gain_c,
  input  logic [DATA_WIDTH-1:0]        pi_gain_g,
  input  logic                         pi_clr_flags,
  output logic                         po_clip,
  output logic                         po_sync_err
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned IW    = $clog2(MAX_DELAY);
  localparam int unsigned DLW   = IW + 1;
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DEPTH = NUM_CH * MAX_DELAY;
  localparam int unsigned AW    = $clog2(DEPTH);

  function automatic logic [DLW-1:0] clamp_delay(input logic [DLW-1:0] v);
    if (v == '0) return DLW'(1);
    if (v > DLW'(MAX_DELAY - 1)) return DLW'(MAX_DELAY - 1);
    return v;
  endfunction

  function automatic logic [AW-1:0] ram_addr(input logic [CW-1:0] ch, input logic [IW-1:0] idx);
    return AW'(32'(ch) * MAX_DELAY + 32'(idx));
  endfunction

  state_e                state_q, state_d;
  logic                  run_q;
  logic [CW-1:0]         ch_cnt_q, smp_ch_q, ch_next;
  logic [IW-1:0]         wr_idx_q;
  logic [DLW-1:0]        primed_q, delay_q, sel_delay;
  mode_e                 mode_q, sel_mode;
  logic signed [DW-1:0]  x_q, y_q, y_mac, d_val, wr_val;
  logic                  last_q;
  logic                  clip_q, sync_err_q;
  logic                  in_hs, frame_start, last_ch, sync_bad;
  logic [DW-1:0]         rd_data;

  logic signed [PW-1:0]  prod_c, prod_g;
  logic signed [DW-1:0]  rnd_c, rnd_g;
  logic signed [DW:0]    sum;
  logic                  clip_c, clip_g, clip_s, mac_clip;

  assign pi_data.tready = run_q && (state_q == S_IDLE);
  assign po_data.tvalid = (state_q == S_OUT);
  assign po_data.tdata  = y_q;
  assign po_data.tlast  = last_q;
  assign po_clip        = clip_q;
  assign po_sync_err    = sync_err_q;

  assign in_hs       = pi_data.tvalid && pi_data.tready;
  assign frame_start = (ch_cnt_q == '0);
  assign last_ch     = (ch_cnt_q == CW'(NUM_CH - 1));
  assign sync_bad    = (pi_data.tlast != last_ch);
  assign ch_next     = last_ch ? '0 : ch_cnt_q + CW'(1);
  // Mode and delay are only taken from the pins at a frame boundary.
  assign sel_mode    = frame_start ? mode_e'(pi_mode) : mode_q;
  assign sel_delay   = frame_start ? clamp_delay(pi_delay) : delay_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_hs) state_d = S_MAC;
      S_MAC:   state_d = S_OUT;
      S_OUT:   if (po_data.tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_val = '0;
    if (primed_q >= delay_q) begin
      d_val = signed'(rd_data);
    end
    prod_c   = PW'(x_q) * PW'(signed'(pi_gain_c));
    prod_g   = PW'(d_val) * PW'(signed'(pi_gain_g));
    rnd_c    = DW'(round_and_clip(ACC_W'(prod_c), DW - 1, DW, clip_c));
    rnd_g    = DW'(round_and_clip(ACC_W'(prod_g), DW - 1, DW, clip_g));
    sum      = (DW + 1)'(rnd_c) + (DW + 1)'(rnd_g);
    y_mac    = x_q;
    mac_clip = 1'b0;
    case (mode_q)
      MODE_FEEDBACK, MODE_FEEDFWD: begin
        y_mac    = DW'(round_and_clip(ACC_W'(sum), SUM_SHIFT, DW, clip_s));
        mac_clip = clip_c | clip_g | clip_s;
      end
      default: begin
        clip_s = 1'b0;
      end
    endcase
    wr_val = (mode_q == MODE_FEEDBACK) ? y_mac : x_q;
  end

  echo_delay_ram #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) u_ram (
    .pi_clk  (pi_clk),
    .wr_en   (state_q == S_MAC),
    .wr_addr (ram_addr(smp_ch_q, wr_idx_q)),
    .wr_data (wr_val),
    .rd_en   (in_hs),
    .rd_addr (ram_addr(ch_cnt_q, wr_idx_q - IW'(sel_delay))),
    .rd_data (rd_data)
  );

  always_ff @(posedge pi_clk or negedge pi_areset_n) begin
    if (!pi_areset_n) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      ch_cnt_q   <= '0;
      smp_ch_q   <= '0;
      wr_idx_q   <= '0;
      primed_q   <= '0;
      delay_q    <= DLW'(1);
      mode_q     <= MODE_BYPASS;
      x_q        <= '0;
      y_q        <= '0;
      last_q     <= 1'b0;
      clip_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (in_hs) begin
        x_q      <= signed'(pi_data.tdata);
        last_q   <= pi_data.tlast;
        smp_ch_q <= ch_cnt_q;
        ch_cnt_q <= sync_bad ? '0 : ch_next;
        if (frame_start) begin
          mode_q  <= sel_mode;
          delay_q <= sel_delay;
          if (sel_mode != mode_q || sel_delay != delay_q) begin
            primed_q <= '0;
          end
        end
      end
      if (state_q == S_MAC) begin
        y_q <= y_mac;
        if (smp_ch_q == CW'(NUM_CH - 1)) begin
          wr_idx_q <= wr_idx_q + IW'(1);
          if (primed_q < DLW'(MAX_DELAY)) begin
            primed_q <= primed_q + DLW'(1);
          end
        end
      end
      // Clear first so a same-cycle set takes priority.
      if (pi_clr_flags) begin
        clip_q     <= 1'b0;
        sync_err_q <= 1'b0;
      end
      if (state_q == S_MAC && mac_clip) begin
        clip_q <= 1'b1;
      end
      if (in_hs && sync_bad) begin
        sync_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_mc.sv
// Randomized self-checking bench for echo_mc against a frame-history reference model.
module tb_echo_mc;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int MD  = 16;
  localparam int DLW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     mode;
  logic [DLW-1:0] delay;
  logic [15:0]    gain_c, gain_g;
  logic           clr;
  logic           clip, sync_err;

  axis_if #(.DATA_WIDTH(DW)) s_if ();
  axis_if #(.DATA_WIDTH(DW)) m_if ();

  echo_mc #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .MAX_DELAY  (MD)
  ) dut (
    .pi_clk       (clk),
    .pi_areset_n  (rst_n),
    .pi_data      (s_if),
    .po_data      (m_if),
    .pi_mode      (mode),
    .pi_delay     (delay),
    .pi_gain_c    (gain_c),
    .pi_gain_g    (gain_g),
    .pi_clr_flags (clr),
    .po_clip      (clip),
    .po_sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference model: stored values kept per absolute frame number and channel.
  int      m_ch, m_since, m_mode, m_D;
  longint  m_frame = 0;
  bit      m_clip, m_sync;
  shortint hist [longint];

  function automatic int clampd(int v);
    if (v == 0) return 1;
    if (v > MD - 1) return MD - 1;
    return v;
  endfunction

  function automatic longint sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_ch = 0; m_since = 0; m_mode = -1; m_D = -1; m_clip = 0; m_sync = 0;
  endtask

  task automatic model_step(input shortint x, input bit last, output shortint y);
    int ch;
    longint a, b, s, dd, key;
    if (m_ch == 0) begin
      int nm, nd;
      nm = int'(mode);
      nd = clampd(int'(delay));
      if (nm != m_mode || nd != m_D) m_since = 0;
      m_mode = nm;
      m_D = nd;
    end
    ch = m_ch;
    dd = 0;
    key = (m_frame - m_D) * NCH + ch;
    if (m_since >= m_D && hist.exists(key)) dd = hist[key];
    if (m_mode == 1 || m_mode == 2) begin
      a = (longint'(shortint'(gain_c)) * longint'(x) + 16384) >>> 15;
      b = (longint'(shortint'(gain_g)) * dd + 16384) >>> 15;
      if (sat16(a) != a || sat16(b) != b) m_clip = 1;
      s = sat16(a) + sat16(b);
      if (sat16(s) != s) m_clip = 1;
      y = shortint'(sat16(s));
    end else begin
      y = x;
    end
    hist[m_frame * NCH + ch] = (m_mode == 1) ? y : x;
    if (last != (ch == NCH - 1)) m_sync = 1;
    if (ch == NCH - 1) begin
      m_frame++;
      m_since++;
    end
    m_ch = (last != (ch == NCH - 1)) ? 0 : (ch + 1) % NCH;
  endtask

  task automatic xfer(input logic [15:0] x, input logic last, input int unsigned w,
                      output logic [15:0] y, output logic yl);
    int unsigned n;
    logic [15:0] y0;
    y = '0; yl = 1'b0;
    s_if.tdata = x; s_if.tlast = last; s_if.tvalid = 1'b1;
    n = 0;
    while (s_if.tready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (s_if.tready !== 1'b1) begin
      chk("in_timeout", 0, 1);
      s_if.tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    n = 0;
    while (m_if.tvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (m_if.tvalid !== 1'b1) begin
      chk("out_timeout", 0, 1);
      return;
    end
    y0 = m_if.tdata;
    repeat (w) begin @(posedge clk); #1; end
    if (w > 0) chk("hold", {m_if.tvalid, m_if.tdata}, {1'b1, y0});
    y = m_if.tdata; yl = m_if.tlast;
    m_if.tready = 1'b1;
    @(posedge clk); #1;
    m_if.tready = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input bit last, input string tag, output shortint y);
    logic [15:0] yo;
    logic yl;
    shortint e;
    model_step(shortint'(x), last, e);
    xfer(x, last, $urandom_range(0, 3), yo, yl);
    y = shortint'(yo);
    chk({tag, "_y"}, y, e);
    chk({tag, "_last"}, yl, last);
    chk({tag, "_clip"}, clip, m_clip);
    chk({tag, "_sync"}, sync_err, m_sync);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_clip = 0; m_sync = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    shortint y;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
    mode = 2'd0; delay = 5'd1; gain_c = '0; gain_g = '0; clr = 1'b0;
    model_reset();

    #1;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_clip", clip, 0);
    chk("rst_sync", sync_err, 0);
    repeat (3) @(posedge clk);
    #1 chk("rst_tready", s_if.tready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_tready", s_if.tready, 1);

    // Feedback impulse: 0x2000, 0x1000 at frame 3, 0x0800 at frame 6.
    mode = 2'd1; delay = 5'd3; gain_c = 16'h4000; gain_g = 16'h4000;
    for (int f = 0; f < 8; f++) begin
      send((f == 0) ? 16'h4000 : 16'h0000, 1'b0, "fb_ch0", y);
      if (f == 0) chk("imp_f0", y, 16'sh2000);
      if (f == 3) chk("imp_f3", y, 16'sh1000);
      if (f == 6) chk("imp_f6", y, 16'sh0800);
      send(16'h0000, 1'b1, "fb_ch1", y);
      chk("imp_ch1", y, 0);
    end

    // Feed-forward saturation from frame 2.
    mode = 2'd2; delay = 5'd2; gain_c = 16'h7FFF; gain_g = 16'h7FFF;
    for (int f = 0; f < 5; f++) begin
      send(16'h7FFF, 1'b0, "ff_ch0", y);
      if (f >= 2) chk("ff_sat0", y, 16'sh7FFF);
      send(16'h7FFF, 1'b1, "ff_ch1", y);
      if (f == 1) chk("ff_noclip", clip, 0);
      if (f >= 2) chk("ff_clip", clip, 1);
    end
    pulse_clr();
    chk("clip_cleared", clip, 0);

    // Bypass and reserved mode with random data and random backpressure.
    for (int f = 0; f < 20; f++) begin
      mode = (f < 10) ? 2'd0 : 2'd3;
      delay = 5'($urandom_range(0, 31));
      gain_c = 16'($urandom); gain_g = 16'($urandom);
      send(16'($urandom), 1'b0, "byp_ch0", y);
      send(16'($urandom), 1'b1, "byp_ch1", y);
    end

    // tlast on a channel-0 sample.
    mode = 2'd0;
    send(16'h1234, 1'b1, "se_bad", y);
    chk("se_flag", sync_err, 1);
    send(16'h0101, 1'b0, "se_ch0", y);
    send(16'h0202, 1'b1, "se_ch1", y);
    pulse_clr();
    chk("se_cleared", sync_err, 0);
    send(16'h0303, 1'b0, "se_ok0", y);
    send(16'h0404, 1'b1, "se_ok1", y);

    // Reset while a sample sits in S_MAC; stale delay-line content must stay masked.
    mode = 2'd2; delay = 5'd4; gain_c = 16'h4000; gain_g = 16'h7000;
    s_if.tdata = 16'h5555; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mac_rst_tvalid", m_if.tvalid, 0);
    chk("mac_rst_tready", s_if.tready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int f = 0; f < 8; f++) begin
      send(16'($urandom), 1'b0, "rr_ch0", y);
      send(16'($urandom), 1'b1, "rr_ch1", y);
    end

    // Delay clamp low: pi_delay=0 behaves as D=1.
    mode = 2'd1; delay = 5'd0; gain_c = 16'h4000; gain_g = 16'h6000;
    for (int f = 0; f < 6; f++) begin
      send(16'($urandom_range(0, 16'h3FFF)), 1'b0, "d0_ch0", y);
      send(16'($urandom_range(0, 16'h3FFF)), 1'b1, "d0_ch1", y);
    end

    // Delay clamp high: pi_delay=MAX_DELAY behaves as MAX_DELAY-1, across index wrap.
    mode = 2'd2; delay = 5'(MD); gain_c = 16'h3000; gain_g = 16'h5000;
    for (int f = 0; f < 2 * MD + 6; f++) begin
      send(16'($urandom), 1'b0, "dmax_ch0", y);
      send(16'($urandom), 1'b1, "dmax_ch1", y);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
